mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Data-memory-side responder for the pipelined MIPS core's data port; it answers the MEM-stage access (memwrite, memaddr, memwritedata) and returns memreaddata.
- Decodes each access to one of two targets:
  - a word RAM region;
  - a small memory-mapped I/O region holding a free-running timer with compare match, an LED register and a byte transmit FIFO drained through a valid/ready port.
- Reads are combinational, so the core samples read data in the same MEM cycle. Writes commit on the clock edge.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two; RAM occupies byte addresses 0 .. RAM_WORDS*4-1.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- IO_BASE, 32'hFFFF_0000, base byte address of the I/O register block.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- memwrite  input  1  write strobe from the core's MEM stage.
- memaddr  input  32  byte address; bits [1:0] ignored (word access only).
- memwritedata  input  32  store data.
- memreaddata  output  32  read data, combinational from memaddr and current state.
- tx_valid  output  1  TX FIFO non-empty.
- tx_data  output  8  head byte of the TX FIFO.
- tx_ready  input  1  consumer accepts the head byte when tx_valid && tx_ready.
- led  output  16  LED register contents.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - led=0, timer count=0, cmp=32'hFFFF_FFFF, match=0, overflow=0.
  - FIFO empty, so tx_valid=0. tx_data is don't-care while empty.
  - RAM contents are not reset.
- Address decode, word-aligned:
  - RAM: memaddr < RAM_WORDS*4, index = memaddr[log2(RAM_WORDS)+1:2].
  - IO_BASE+0x00 COUNT (RW): read returns the count; a write loads memwritedata.
  - IO_BASE+0x04 CMP (RW).
  - IO_BASE+0x08 STATUS:
    - read bits: bit0 match (sticky), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky), bits[7:4] fifo count, other bits 0.
    - write: a 1 in bit0 clears match; a 1 in bit3 clears overflow.
  - IO_BASE+0x0C TX_DATA (WO): a write pushes memwritedata[7:0]; a read returns 0.
  - IO_BASE+0x10 LED (RW): holds bits [15:0]; a read is zero-extended.
  - Any other address: read returns 0, write ignored.
- Read timing:
  - memreaddata is purely combinational with zero latency.
  - Read-during-write to the same location returns the pre-edge value; the new value is visible the cycle after the edge.
- Timer:
  - Increments by 1 every cycle, wrapping from 32'hFFFF_FFFF to 0.
  - A COUNT write takes priority over the increment: the next cycle reads exactly memwritedata.
  - match sets on any cycle where the current count == cmp.
  - A match set coincident with a STATUS clear write: set wins.
- TX FIFO:
  - Push on a TX_DATA write. Pop when tx_valid && tx_ready.
  - No fall-through: a byte pushed into an empty FIFO makes tx_valid=1 the next cycle.
  - Push while full with no pop: the byte is dropped, overflow is set, contents are unchanged.
  - Push while full with a simultaneous pop: the push is accepted and the count stays at FIFO_DEPTH.
  - Push and pop on a non-full, non-empty FIFO: the count is unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - tx_data must be held stable while tx_valid=1 and tx_ready=0.
- Reset asserted mid-operation:
  - Next cycle equals the reset state: FIFO flushed, sticky bits cleared.
  - Any memwrite during a reset cycle is ignored, including RAM writes.

Decomposition:
- Shared package mem_responder_pkg holds:
  - register offset constants: OFF_COUNT, OFF_CMP, OFF_STATUS, OFF_TXDATA, OFF_LED;
  - STATUS bit indices: ST_MATCH, ST_FULL, ST_EMPTY, ST_OVF, ST_CNT_LSB.
- One sub-module tx_fifo:
  - parameterised width and depth;
  - ports push/din, pop/dout, full, empty, count;
  - synchronous reset.
- The top level owns decode, RAM, timer, LED and the read mux.

Test Plan:
- RAM round-trip: reset; write 32'hDEADBEEF to 0x10; same-cycle read of 0x10 shows the old value; next cycle reads 32'hDEADBEEF. Read of 0x2000 (unmapped) = 0.
- Timer match: write COUNT=100, CMP=105. STATUS bit0 = 0 for the 5 cycles after the write, then 1 and sticky. Writing STATUS=1 clears it. COUNT loaded with 32'hFFFF_FFFF reads 0 one cycle later (wrap).
- FIFO fill and overflow, tx_ready=0:
  - Push 0x41, 0x42, 0x43, 0x44: tx_valid rises the cycle after the first push; STATUS shows full=1, count=4.
  - A 5th push of 0x45 is dropped and sets overflow=1.
  - Raising tx_ready drains 0x41, 0x42, 0x43, 0x44 in order, then empty=1.
- Simultaneous push/pop when full: tx_ready=1 and push 0x55 in the same cycle. Count stays 4; 0x55 emerges last.
- LED plus reset mid-run: write LED=32'h1234_ABCD; led=16'hABCD and the read returns 32'h0000_ABCD. Assert reset for 1 cycle with the FIFO non-empty: led=0, tx_valid=0, COUNT=0, while RAM data written earlier is retained.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared constants for the MIPS data-port responder.
// Holds the I/O register offsets (relative to IO_BASE), the STATUS bit layout
// and a helper that packs the STATUS read word.
package mem_responder_pkg;

   localparam logic [31:0] OFF_COUNT  = 32'h0000_0000;
   localparam logic [31:0] OFF_CMP    = 32'h0000_0004;
   localparam logic [31:0] OFF_STATUS = 32'h0000_0008;
   localparam logic [31:0] OFF_TXDATA = 32'h0000_000C;
   localparam logic [31:0] OFF_LED    = 32'h0000_0010;

   localparam int unsigned ST_MATCH   = 0;
   localparam int unsigned ST_FULL    = 1;
   localparam int unsigned ST_EMPTY   = 2;
   localparam int unsigned ST_OVF     = 3;
   localparam int unsigned ST_CNT_LSB = 4;

   function automatic logic [31:0] pack_status(input logic       match,
                                               input logic       full,
                                               input logic       empty,
                                               input logic       ovf,
                                               input logic [3:0] cnt);
      logic [31:0] s;
      s                   = '0;
      s[ST_MATCH]         = match;
      s[ST_FULL]          = full;
      s[ST_EMPTY]         = empty;
      s[ST_OVF]           = ovf;
      s[ST_CNT_LSB +: 4]  = cnt;
      return s;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Data-port bundle between the core's MEM stage and the memory responder.
//   memwrite/memaddr/memwritedata : access request from the core
//   memreaddata                   : combinational read data back to the core
//   tx_valid/tx_data/tx_ready     : byte stream drained from the TX FIFO
//   led                           : LED register contents
// master = core/consumer side, slave = responder side.
interface mem_responder_if;
   logic        memwrite;
   logic [31:0] memaddr;
   logic [31:0] memwritedata;
   logic [31:0] memreaddata;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic [15:0] led;

   modport master (
      output memwrite, memaddr, memwritedata, tx_ready,
      input  memreaddata, tx_valid, tx_data, led
   );

   modport slave (
      input  memwrite, memaddr, memwritedata, tx_ready,
      output memreaddata, tx_valid, tx_data, led
   );
endinterface

// File: rtl/mem_responder_tx_fifo.sv
// Synchronous FIFO without fall-through.
//   push/din   : write port; a push while full is accepted only with a pop
//   pop/dout   : dout is the head entry, pop ignored while empty
//   full/empty : occupancy flags
//   count      : number of stored entries (0 .. DEPTH)
module mem_responder_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned Aw   = $clog2(DEPTH);
   localparam int unsigned CntW = Aw + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [Aw-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(DEPTH));
   assign do_pop  = pop && !empty;
   // When full, the slot being written is the one the pop frees this edge.
   assign do_push = push && (!full || do_pop);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + Aw'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + Aw'(1);
         count_q <= count_d;
      end
   end

   // Storage needs no reset; the pointers define validity.
   always_ff @(posedge clk) begin
      if (!reset && do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/mem_responder.sv
// Data-memory responder for the pipelined MIPS core.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_responder_if.slave (access request, read data, TX stream, LEDs)
// Decodes word accesses to a RAM region at address 0 or to an I/O block at
// IO_BASE (timer COUNT/CMP, STATUS, TX_DATA push, LED). Reads are
// combinational; writes commit on the rising edge.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned RAM_WORDS  = 64,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave bus
);
   localparam int unsigned RamAw    = $clog2(RAM_WORDS);
   localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] RamBytes = 32'(RAM_WORDS * 4);

   logic [31:0]      word_addr;
   logic             is_ram;
   logic [RamAw-1:0] ram_idx;
   logic             sel_count, sel_cmp, sel_status, sel_txdata, sel_led;
   logic             wr_count, wr_cmp, wr_status, wr_txdata, wr_led;

   logic [31:0]      ram_q [RAM_WORDS];
   logic [31:0]      count_q, count_d;
   logic [31:0]      cmp_q;
   logic             match_q, match_d;
   logic             ovf_q, ovf_d;
   logic [15:0]      led_q;

   logic             fifo_full, fifo_empty, fifo_pop;
   logic [CntW-1:0]  fifo_count;
   logic [31:0]      rdata;

   assign word_addr  = {bus.memaddr[31:2], 2'b00};
   assign is_ram     = (bus.memaddr < RamBytes);
   assign ram_idx    = bus.memaddr[RamAw+1:2];

   assign sel_count  = (word_addr == IO_BASE + OFF_COUNT);
   assign sel_cmp    = (word_addr == IO_BASE + OFF_CMP);
   assign sel_status = (word_addr == IO_BASE + OFF_STATUS);
   assign sel_txdata = (word_addr == IO_BASE + OFF_TXDATA);
   assign sel_led    = (word_addr == IO_BASE + OFF_LED);

   assign wr_count   = bus.memwrite && sel_count;
   assign wr_cmp     = bus.memwrite && sel_cmp;
   assign wr_status  = bus.memwrite && sel_status;
   assign wr_txdata  = bus.memwrite && sel_txdata;
   assign wr_led     = bus.memwrite && sel_led;

   assign fifo_pop   = bus.tx_ready && !fifo_empty;

   mem_responder_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata),
      .din   (bus.memwritedata[7:0]),
      .pop   (fifo_pop),
      .dout  (bus.tx_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!reset && bus.memwrite && is_ram) ram_q[ram_idx] <= bus.memwritedata;
   end

   // Sticky bits: a set event in the same cycle as a clear write wins.
   always_comb begin
      count_d = wr_count ? bus.memwritedata : count_q + 32'd1;

      match_d = match_q;
      if (wr_status && bus.memwritedata[ST_MATCH]) match_d = 1'b0;
      if (count_q == cmp_q)                        match_d = 1'b1;

      ovf_d = ovf_q;
      if (wr_status && bus.memwritedata[ST_OVF])   ovf_d = 1'b0;
      if (wr_txdata && fifo_full && !fifo_pop)     ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         cmp_q   <= 32'hFFFF_FFFF;
         match_q <= 1'b0;
         ovf_q   <= 1'b0;
         led_q   <= '0;
      end else begin
         count_q <= count_d;
         match_q <= match_d;
         ovf_q   <= ovf_d;
         if (wr_cmp) cmp_q <= bus.memwritedata;
         if (wr_led) led_q <= bus.memwritedata[15:0];
      end
   end

   always_comb begin
      rdata = '0;
      if (is_ram)          rdata = ram_q[ram_idx];
      else if (sel_count)  rdata = count_q;
      else if (sel_cmp)    rdata = cmp_q;
      else if (sel_status) rdata = pack_status(match_q, fifo_full, fifo_empty, ovf_q,
                                               4'(fifo_count));
      else if (sel_led)    rdata = {16'h0000, led_q};
   end

   assign bus.memreaddata = rdata;
   assign bus.tx_valid    = !fifo_empty;
   assign bus.led         = led_q;
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
   localparam logic [31:0] IoBase = 32'hFFFF_0000;
   localparam logic [31:0] ACount = IoBase + 32'h00;
   localparam logic [31:0] ACmp   = IoBase + 32'h04;
   localparam logic [31:0] AStat  = IoBase + 32'h08;
   localparam logic [31:0] ATx    = IoBase + 32'h0C;
   localparam logic [31:0] ALed   = IoBase + 32'h10;
   localparam logic [31:0] AIdle  = 32'h0000_2000;
   localparam int          Depth  = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_responder_if bus ();

   mem_responder #(
      .RAM_WORDS  (64),
      .FIFO_DEPTH (Depth),
      .IO_BASE    (IoBase)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Behavioural model
   logic [31:0] cnt_m, cmp_m;
   logic        match_m, ovf_m;
   logic [15:0] led_m;
   logic [7:0]  q[$];
   logic [31:0] ram_m [64];
   bit          ram_k [64];

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
      logic [31:0] wa;
      wa    = {a[31:2], 2'b00};
      known = 1;
      if (a < 32'd256) begin
         known = ram_k[a[7:2]];
         return ram_m[a[7:2]];
      end
      case (wa)
         ACount:  return cnt_m;
         ACmp:    return cmp_m;
         AStat:   return {24'h0, 4'(q.size()), ovf_m, (q.size() == 0), (q.size() == Depth),
                          match_m};
         ALed:    return {16'h0, led_m};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step();
      logic [31:0] wa, wd;
      logic        we, pu, po, m_set, drop;
      wa = {bus.memaddr[31:2], 2'b00};
      wd = bus.memwritedata;
      we = bus.memwrite;
      if (reset) begin
         cnt_m = 0; cmp_m = 32'hFFFF_FFFF; match_m = 0; ovf_m = 0; led_m = 0;
         q.delete();
         return;
      end
      po    = (q.size() != 0) && bus.tx_ready;
      pu    = we && (wa == ATx);
      drop  = pu && (q.size() == Depth) && !po;
      m_set = (cnt_m == cmp_m);
      if (we && wa == AStat && wd[0]) match_m = 0;
      if (m_set) match_m = 1;
      if (we && wa == AStat && wd[3]) ovf_m = 0;
      if (drop) ovf_m = 1;
      cnt_m = (we && wa == ACount) ? wd : cnt_m + 1;
      if (we && wa == ACmp) cmp_m = wd;
      if (we && wa == ALed) led_m = wd[15:0];
      if (we && bus.memaddr < 32'd256) begin
         ram_m[bus.memaddr[7:2]] = wd;
         ram_k[bus.memaddr[7:2]] = 1;
      end
      if (po) void'(q.pop_front());
      if (pu && !drop) q.push_back(wd[7:0]);
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      logic [31:0] e;
      bit          k;
      if (chk_en) begin
         e = model_read(bus.memaddr, k);
         if (k) check("rdata", bus.memreaddata, e);
         check("tx_valid", {31'h0, bus.tx_valid}, {31'h0, (q.size() != 0)});
         if (q.size() != 0) check("tx_data", {24'h0, bus.tx_data}, {24'h0, q[0]});
         check("led", {16'h0, bus.led}, {16'h0, led_m});
      end
   end

   task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
      bus.memwrite     = we;
      bus.memaddr      = a;
      bus.memwritedata = d;
      #2;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset            = 1;
      bus.memwrite     = 0;
      bus.memaddr      = AIdle;
      bus.memwritedata = 0;
      bus.tx_ready     = 0;
      for (int i = 0; i < 64; i++) ram_k[i] = 0;
      next();
      chk_en = 1;

      // Reset state (reset still held)
      cyc(0, ACount, 0); check("rst_count", bus.memreaddata, 32'h0); next();
      cyc(0, ACmp, 0);   check("rst_cmp", bus.memreaddata, 32'hFFFF_FFFF); next();
      cyc(0, AStat, 0);  check("rst_status", bus.memreaddata, 32'h4);
      check("rst_txvalid", {31'h0, bus.tx_valid}, 32'h0); next();
      cyc(0, ALed, 0);   check("rst_led", {16'h0, bus.led}, 32'h0); next();
      reset = 0;

      // RAM round trip
      cyc(1, 32'h10, 32'h1111_1111); next();
      cyc(1, 32'h10, 32'hDEAD_BEEF); check("ram_rdw_old", bus.memreaddata, 32'h1111_1111);
      next();
      cyc(0, 32'h10, 0);    check("ram_new", bus.memreaddata, 32'hDEAD_BEEF); next();
      cyc(0, 32'h12, 0);    check("ram_low_bits", bus.memreaddata, 32'hDEAD_BEEF); next();
      cyc(0, AIdle, 0);     check("unmapped", bus.memreaddata, 32'h0); next();
      cyc(1, 32'hFC, 32'hA5A5_0001); next();
      cyc(0, 32'hFC, 0);    check("ram_top", bus.memreaddata, 32'hA5A5_0001); next();
      cyc(0, 32'h100, 0);   check("ram_beyond", bus.memreaddata, 32'h0); next();

      // Timer compare match
      cyc(1, ACmp, 32'd105); next();
      cyc(1, ACount, 32'd100); next();
      cyc(0, ACount, 0); check("cnt_loaded", bus.memreaddata, 32'd100); next();
      for (int i = 0; i < 5; i++) begin
         cyc(0, AStat, 0); check("match_low", {31'h0, bus.memreaddata[0]}, 32'h0); next();
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, AStat, 0); check("match_high", {31'h0, bus.memreaddata[0]}, 32'h1); next();
      end
      cyc(1, AStat, 32'h1); next();
      cyc(0, AStat, 0); check("status_clr", bus.memreaddata, 32'h4); next();
      cyc(1, ACount, 32'hFFFF_FFFF); next();
      cyc(0, ACount, 0); check("cnt_max", bus.memreaddata, 32'hFFFF_FFFF); next();
      cyc(0, ACount, 0); check("cnt_wrap", bus.memreaddata, 32'h0); next();

      // FIFO fill and overflow
      bus.tx_ready = 0;
      cyc(1, ATx, 32'h41); check("txv_first", {31'h0, bus.tx_valid}, 32'h0); next();
      cyc(1, ATx, 32'h42); check("txv_rise", {31'h0, bus.tx_valid}, 32'h1);
      check("tx_head", {24'h0, bus.tx_data}, 32'h41); next();
      cyc(1, ATx, 32'h43); next();
      cyc(1, ATx, 32'h44); next();
      cyc(0, AStat, 0); check("stat_full", bus.memreaddata, 32'h42); next();
      cyc(1, ATx, 32'h45); next();
      cyc(0, AStat, 0); check("stat_ovf", bus.memreaddata, 32'h4A); next();
      bus.tx_ready = 1;
      for (int b = 8'h41; b <= 8'h44; b++) begin
         cyc(0, AIdle, 0); check("drain", {24'h0, bus.tx_data}, 32'(b)); next();
      end
      cyc(0, AStat, 0); check("stat_drained", bus.memreaddata, 32'h0C);
      check("txv_drained", {31'h0, bus.tx_valid}, 32'h0); next();
      cyc(1, AStat, 32'h8); next();
      cyc(0, AStat, 0); check("ovf_clr", bus.memreaddata, 32'h4); next();

      // Push and pop on a full FIFO
      bus.tx_ready = 0;
      for (int i = 1; i <= 4; i++) begin
         cyc(1, ATx, 32'(i)); next();
      end
      bus.tx_ready = 1;
      cyc(1, ATx, 32'h55); check("pp_head", {24'h0, bus.tx_data}, 32'h01); next();
      cyc(0, AStat, 0); check("pp_stat", bus.memreaddata, 32'h42);
      check("pp_d2", {24'h0, bus.tx_data}, 32'h02); next();
      cyc(0, AIdle, 0); check("pp_d3", {24'h0, bus.tx_data}, 32'h03); next();
      cyc(0, AIdle, 0); check("pp_d4", {24'h0, bus.tx_data}, 32'h04); next();
      cyc(0, AIdle, 0); check("pp_d55", {24'h0, bus.tx_data}, 32'h55); next();
      cyc(0, AIdle, 0); check("pp_empty", {31'h0, bus.tx_valid}, 32'h0); next();

      // LED, then reset mid-run
      bus.tx_ready = 0;
      cyc(1, ALed, 32'h1234_ABCD); next();
      cyc(0, ALed, 0); check("led_out", {16'h0, bus.led}, 32'h0000_ABCD);
      check("led_rd", bus.memreaddata, 32'h0000_ABCD); next();
      cyc(1, ATx, 32'h77); next();
      cyc(0, AIdle, 0); check("txv_pre_rst", {31'h0, bus.tx_valid}, 32'h1); next();
      reset = 1;
      cyc(1, 32'h10, 32'hCAFE_F00D); next();
      reset = 0;
      cyc(0, ACount, 0); check("post_rst_count", bus.memreaddata, 32'h0);
      check("post_rst_led", {16'h0, bus.led}, 32'h0);
      check("post_rst_txv", {31'h0, bus.tx_valid}, 32'h0); next();
      cyc(0, 32'h10, 0); check("ram_kept", bus.memreaddata, 32'hDEAD_BEEF); next();

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
